// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
//
// Upstream stage of an N-row systolic PE array. A tile of up to K_MAX
// activation column-vectors is collected over a valid/ready stream. On start,
// the tile is replayed onto the array's west inputs with row r delayed by r
// cycles, forming the diagonal wavefront the array expects.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the FSM state, never on in_valid. A source that
// sees in_ready=0 must hold in_data/in_last stable until the beat transfers.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high
//   in_valid  in_data beat valid
//   in_ready  feeder can accept a beat (high in IDLE and FILL)
//   in_data   one column-vector; element r in [r*DW +: DW] is for row r
//   in_last   final beat of the tile
//   start     begin streaming the loaded tile (honoured only in LOADED)
//   flush     (FEEDER_REPLAY_EN only) drop the loaded tile while in LOADED
//   out_west  skewed row data; slice r drives the west input of row r
//   compute   array compute enable, aligned with out_west
//   done      one-cycle pulse on the cycle after the last streamed step
//   tile_len  number of beats currently loaded
//
// Optional feature macro: FEEDER_REPLAY_EN. When defined, a finished run
// returns to LOADED with the tile kept, so another start replays it, and the
// flush input discards the tile. When undefined, a run always returns to IDLE
// and clears the tile.
//
// The FSM state is held in the internal signal 'state' for probing.
// -----------------------------------------------------------------------------
module systolic_skew_feeder #(
    parameter int DW    = 16,
    parameter int N     = 3,
    parameter int K_MAX = 8,
    localparam int LW   = $clog2(K_MAX + 1),
    localparam int TW   = $clog2(K_MAX + N),
    localparam int AW   = (K_MAX > 1) ? $clog2(K_MAX) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
    input  logic            in_last,
    input  logic            start,
`ifdef FEEDER_REPLAY_EN
    input  logic            flush,
`endif
    output logic [N*DW-1:0] out_west,
    output logic            compute,
    output logic            done,
    output logic [LW-1:0]   tile_len
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        LOADED = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t          state;
    logic [TW-1:0]   t;
    logic [N*DW-1:0] buf_mem [K_MAX];
    logic [N*DW-1:0] west_next;
    logic [AW-1:0]   wr_addr;
    logic            accept;
    logic            last_step;

    assign in_ready = (state == IDLE) || (state == FILL);
    assign accept   = in_valid && in_ready;

    // tile_len doubles as the write pointer; the first beat always lands at 0.
    assign wr_addr = (state == IDLE) ? '0 : tile_len[AW-1:0];

    // Final step registers t = tile_len + N - 2, so compute is high for
    // tile_len + N - 1 cycles and the last row's last element gets out.
    assign last_step = (int'(t) == int'(tile_len) + N - 2);

    // Row r shows element t-r of the tile; outside the tile it shows zero.
    always_comb begin
        west_next = '0;
        for (int r = 0; r < N; r++) begin : g_row
            int k;
            k = int'(t) - r;
            if (k >= 0 && k < int'(tile_len)) begin
                west_next[r*DW +: DW] = buf_mem[k[AW-1:0]][r*DW +: DW];
            end
        end
    end

    // Tile storage has no reset: its contents only matter below tile_len.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_mem[wr_addr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tile_len <= '0;
            t        <= '0;
            out_west <= '0;
            compute  <= 1'b0;
            done     <= 1'b0;
        end else begin
            out_west <= '0;
            compute  <= 1'b0;
            // compute still high outside RUN means the last step just ended.
            done     <= compute && (state != RUN);

            case (state)
                IDLE: begin
                    if (accept) begin
                        tile_len <= LW'(1);
                        state    <= (in_last || K_MAX == 1) ? LOADED : FILL;
                    end
                end

                FILL: begin
                    if (accept) begin
                        tile_len <= tile_len + LW'(1);
                        // A full buffer closes the tile regardless of in_last.
                        if (in_last || tile_len == LW'(K_MAX - 1)) begin
                            state <= LOADED;
                        end
                    end
                end

                LOADED: begin
                    if (start) begin
                        state <= RUN;
                        t     <= '0;
                    end
`ifdef FEEDER_REPLAY_EN
                    else if (flush) begin
                        state    <= IDLE;
                        tile_len <= '0;
                    end
`endif
                end

                RUN: begin
                    out_west <= west_next;
                    compute  <= 1'b1;
                    if (last_step) begin
                        t <= '0;
`ifdef FEEDER_REPLAY_EN
                        state <= LOADED;
`else
                        state    <= IDLE;
                        tile_len <= '0;
`endif
                    end else begin
                        t <= t + TW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream stage of the 3x3 systolic PE array.
- Buffers a tile of activation column-vectors arriving over a valid/ready stream.
- On start, replays the tile onto the array's west inputs with row r delayed by r cycles (diagonal wavefront).
- Drives the array's compute strobe for exactly the streaming window and pulses done at the end.

Parameters:
- DW, 16, width of one activation element.
- N, 3, number of array rows (west inputs).
- K_MAX, 8, maximum column-vectors per tile (buffer depth).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  in_data beat valid.
- in_ready  out  1  feeder can accept a beat.
- in_data  in  N*DW  one column-vector; element r in [r*DW +: DW] is for row r.
- in_last  in  1  marks the final beat of the tile.
- start  in  1  begin streaming the loaded tile.
- out_west  out  N*DW  skewed row data; slice r drives array west input of row r (rows 0,1,2 -> P0,P3,P6).
- compute  out  1  array compute enable, aligned with out_west.
- done  out  1  one-cycle pulse after the stream completes.
- tile_len  out  clog2(K_MAX+1)  number of beats currently loaded.

Behaviour:
- Reset values: state IDLE; out_west=0; compute=0; done=0; tile_len=0; write pointer=0; step counter=0; in_ready=1. Buffer contents are don't-care.
- States:
  - IDLE: in_ready=1. An accepted beat (in_valid&in_ready) writes buf[0], sets tile_len=1 and goes to FILL, or to LOADED if in_last or K_MAX==1.
  - FILL: in_ready=1. Each accepted beat writes buf[tile_len] and increments tile_len. Goes to LOADED when the accepted beat has in_last=1, or when it makes tile_len==K_MAX (in_last ignored in that case). in_valid=0 holds state.
  - LOADED: in_ready=0. start=1 goes to RUN with step t=0. start in any other state is ignored, including the cycle FILL completes.
  - RUN: in_ready=0. Each cycle registers, for every row r, out_west[r] = buf[t-r][r] if 0 <= t-r < tile_len, else 0. compute=1 and t increments. After registering t = tile_len+N-2, goes to IDLE.
- RUN exit: on the cycle after the last RUN step, compute=0, out_west=0, done=1 for exactly one cycle, tile_len=0.
- Latency:
  - First out_west/compute appear the cycle after start is sampled.
  - compute stays high for exactly tile_len+N-1 consecutive cycles.
  - Row 0 element k appears on stream cycle k; row r element k appears on stream cycle k+r.
- Outside RUN, out_west=0 and compute=0.
- in_data is captured only on an accepted beat. Data presented while in_ready=0 is not consumed and must be held by the source.
- Reset asserted mid-FILL or mid-RUN: immediate return to reset values; compute drops asynchronously; no done pulse.
- Counter widths are sized so that tile_len reaches K_MAX and t reaches K_MAX+N-2 without wrap.

Optional Feature:
- Macro FEEDER_REPLAY_EN.
- Defined:
  - RUN exits to LOADED instead of IDLE; tile_len and buffer are kept, so a new start replays the same tile.
  - Extra input port flush (1 bit): in LOADED, moves to IDLE and clears tile_len; ignored in other states.
  - done still pulses after every run.
- Undefined:
  - No flush port.
  - RUN always exits to IDLE and clears tile_len, as described above.

Test Plan:
- Reset then 3 beats {row0,row1,row2} = {1,2,3},{4,5,6},{7,8,9} with in_last on beat 3, then start -> compute high 5 cycles. Row0 = 1,4,7,0,0; row1 = 0,2,5,8,0; row2 = 0,0,3,6,9. done pulses on the 6th cycle after start.
- 8 beats with in_last=0 throughout -> LOADED after 8th beat, in_ready=0, tile_len=8. 9th beat held, not consumed. Start gives compute for 10 cycles.
- Single beat {10,20,30} with in_last -> streams row0 = 10,0,0; row1 = 0,20,0; row2 = 0,0,30. compute 3 cycles.
- start pulsed in IDLE and in FILL -> no compute, no done. in_valid gaps during FILL -> tile_len increments only on accepted beats.
- rst asserted on 2nd RUN cycle -> compute=0 and out_west=0 at once, no done, in_ready=1, tile_len=0.
- FEEDER_REPLAY_EN defined: load 2 beats, start twice -> two identical 4-cycle streams and two done pulses. flush then start -> no stream; in_ready returns to 1.
